register_file: RTL and testbench
================================

REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 The block SHALL have parameter N, default 4, meaning address width in bits, giving 2**N registers.
REQ-002 The block SHALL have parameter W, default 16, meaning data word width in bits.
REQ-003 Port clk SHALL be an input, 1 bit, the single clock; all state updates occur on its rising edge.
REQ-004 Port rst SHALL be an input, 1 bit, reset, synchronous and active-low.
REQ-005 Port we SHALL be an input, 1 bit, write enable, active-high.
REQ-006 Port addr_rd SHALL be an input, N bits, write (destination) register address.
REQ-007 Port addr_rs1 SHALL be an input, N bits, read port 1 register address.
REQ-008 Port addr_rs2 SHALL be an input, N bits, read port 2 register address.
REQ-009 Port data_in SHALL be an input, W bits, write data.
REQ-010 Port rs1 SHALL be an output, W bits, read port 1 data.
REQ-011 Port rs2 SHALL be an output, W bits, read port 2 data.

Function
REQ-012 Storage SHALL be 2**N registers of W bits, indexed 0 to 2**N-1.
REQ-013 A write SHALL occur on a rising clk edge when rst is high, we=1 and addr_rd != 0: register[addr_rd] <= data_in.
REQ-014 With we=0, no register SHALL change, whatever addr_rd and data_in are.
REQ-015 Register 0 SHALL read as all zeros at all times; writes to address 0 are ignored.
REQ-016 Reads SHALL be combinational (zero latency): rs1 = register[addr_rs1], rs2 = register[addr_rs2].
REQ-017 The two read ports SHALL be independent; both may address the same register, including the one being written.
REQ-018 A written value SHALL be visible on a read port in the same cycle, immediately after the rising edge that performs the write.
REQ-019 Without REGFILE_BYPASS_EN, a read of addr_rd during a write cycle SHALL return the old contents until the edge.
REQ-020 Each write SHALL overwrite the full W-bit word; there are no partial writes.
REQ-021 The block SHALL have no read enable; address changes alone SHALL update rs1 and rs2.

Reset
REQ-022 While rst=0 at a rising clk edge, all registers SHALL be cleared to 0.
REQ-023 Reset SHALL take priority over a write in the same cycle; the write is discarded.
REQ-024 Asserting reset mid-operation SHALL clear all previously written values; rs1 and rs2 SHALL read 0 after that edge.
REQ-025 Reset SHALL have no asynchronous effect; before the first edge with rst=0, contents are undefined in simulation.

Configuration
REQ-026 Macro REGFILE_BYPASS_EN SHALL, when defined, enable write-to-read forwarding.
REQ-027 With the macro defined, when rst=1, we=1, addr_rd != 0 and addr_rsX == addr_rd, rsX SHALL equal data_in combinationally, before the edge.
REQ-028 With the macro defined, address 0 SHALL still read 0, and forwarding SHALL be suppressed while rst=0.
REQ-029 With the macro undefined, no forwarding logic SHALL exist, and reads SHALL reflect stored contents only.

Verification
REQ-030 Reset, then write 0xABCD to r0; read r0 on both ports -> rs1=rs2=0x0000.
REQ-031 Write r1=0x1234 and r2=0x5678; read (1,2) -> rs1=0x1234, rs2=0x5678; then write r1=0xDEAD -> rs1=0xDEAD, rs2=0x5678.
REQ-032 With addr_rs1=3 and addr_rs2=0, write r3=0xAAAA; 1 ns after the edge -> rs1=0xAAAA, rs2=0x0000; before the edge -> old r3 (no bypass) or 0xAAAA (bypass).
REQ-033 Hold rst=0 for one edge after writes -> rs1=rs2=0 for r1 and r2; with we=1 during reset, the target register still reads 0.
REQ-034 Write ri = i*0x1111 for i=1..7; after each write, read (i, i-1) -> the two values, with r0=0.
REQ-035 With we=0, addr_rd=9 and data_in=0xBEEF across an edge; read r9 -> 0x0000.

Source files
------------

// File: rtl/register_file.sv
// register_file: 2**N x W-bit register file with one write port and two
// independent combinational read ports. Register 0 is hardwired to zero.
// Reset is synchronous and active-low. It clears every register and wins
// over a write in the same cycle.
// Optional feature: define REGFILE_BYPASS_EN to forward write data to a read
// port that addresses the register being written, before the clock edge.
// The default build (macro undefined) reads only stored contents.
module register_file #(
    parameter int N = 4,
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         we,
    input  logic [N-1:0] addr_rd,
    input  logic [N-1:0] addr_rs1,
    input  logic [N-1:0] addr_rs2,
    input  logic [W-1:0] data_in,
    output logic [W-1:0] rs1,
    output logic [W-1:0] rs2
);

    localparam int DEPTH = 2 ** N;

    logic [W-1:0] regs [DEPTH];
    logic         wr_en;

    // A write to address 0 is dropped here, so regs[0] is never loaded.
    assign wr_en = we && (addr_rd != '0);

    // Storage update: the synchronous clear takes priority over a write.
    always_ff @(posedge clk) begin
        if (!rst) begin
            // NOTE: clearing the whole array on reset makes this flop-based
            // storage rather than an inferable RAM. This is intended, because
            // every register must read zero after reset.
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            // NOTE: non-blocking, so a read in the write cycle still returns
            // the old contents until the edge.
            regs[addr_rd] <= data_in;
        end
    end

    // Read ports: zero-latency lookup, optional forwarding, r0 forced to zero.
    always_comb begin
        // NOTE: both outputs get a value first on every path, which prevents
        // latch inference.
        rs1 = regs[addr_rs1];
        rs2 = regs[addr_rs2];
`ifdef REGFILE_BYPASS_EN
        // Forward only when the write will actually happen. Reset suppresses
        // forwarding.
        if (rst && wr_en && (addr_rs1 == addr_rd)) rs1 = data_in;
        if (rst && wr_en && (addr_rs2 == addr_rd)) rs2 = data_in;
`endif
        if (addr_rs1 == '0) rs1 = '0;
        if (addr_rs2 == '0) rs2 = '0;
    end

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file. A plain-array reference model holds
// the architectural register contents. Each cycle the bench checks both read
// ports before and after the edge, using fixed scenarios first and then
// randomized traffic.
module tb_register_file;

    localparam int N = 4;
    localparam int W = 16;
    localparam int DEPTH = 2 ** N;

    logic         clk = 1'b0;
    logic         rst;
    logic         we;
    logic [N-1:0] addr_rd;
    logic [N-1:0] addr_rs1;
    logic [N-1:0] addr_rs2;
    logic [W-1:0] data_in;
    logic [W-1:0] rs1;
    logic [W-1:0] rs2;

    int total = 0;
    int bad   = 0;

    // Reference contents, indexed by register number.
    logic [W-1:0] model [DEPTH];

    register_file #(.N(N), .W(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .we       (we),
        .addr_rd  (addr_rd),
        .addr_rs1 (addr_rs1),
        .addr_rs2 (addr_rs2),
        .data_in  (data_in),
        .rs1      (rs1),
        .rs2      (rs2)
    );

    // Clock: 10 ns period, rising edges at 5, 15, 25, ...
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected read value for an address, given the current inputs and model.
    function automatic logic [W-1:0] exp_read(input logic [N-1:0] a);
        if (a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
        if (rst && we && addr_rd != 0 && a == addr_rd) return data_in;
`endif
        return model[a];
    endfunction

    // Apply one cycle of inputs. The bench checks both ports before the edge,
    // applies the edge to the model, and then checks both ports 1 ns after
    // the edge.
    task automatic cycle(input logic r, input logic w, input logic [N-1:0] rd,
                         input logic [N-1:0] a1, input logic [N-1:0] a2,
                         input logic [W-1:0] d, input string tag);
        rst = r; we = w; addr_rd = rd; addr_rs1 = a1; addr_rs2 = a2; data_in = d;
        #2;
        check({tag, "_pre_rs1"}, rs1, exp_read(a1));
        check({tag, "_pre_rs2"}, rs2, exp_read(a2));
        @(posedge clk);
        if (!r) begin
            for (int i = 0; i < DEPTH; i++) model[i] = '0;
        end else if (w && rd != 0) begin
            model[rd] = d;
        end
        #1;
        check({tag, "_post_rs1"}, rs1, exp_read(a1));
        check({tag, "_post_rs2"}, rs2, exp_read(a2));
    endtask

    initial begin
        rst = 1'b1; we = 1'b0; addr_rd = '0; addr_rs1 = '0; addr_rs2 = '0; data_in = '0;
        for (int i = 0; i < DEPTH; i++) model[i] = 'x;
        @(posedge clk);
        #1;

        // Reset, then check that every register reads zero.
        cycle(1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 16'h0000, "reset");
        for (int i = 1; i < DEPTH; i++) begin
            addr_rs1 = 4'(i); addr_rs2 = 4'(DEPTH - i);
            #1;
            check("reset_all_rs1", rs1, 16'h0000);
            check("reset_all_rs2", rs2, 16'h0000);
        end

        // A write to r0 is ignored.
        cycle(1'b1, 1'b1, 4'd0, 4'd0, 4'd0, 16'hABCD, "r0_write");
        check("r0_rs1", rs1, 16'h0000);
        check("r0_rs2", rs2, 16'h0000);

        // Basic writes and an overwrite.
        cycle(1'b1, 1'b1, 4'd1, 4'd1, 4'd2, 16'h1234, "w_r1");
        cycle(1'b1, 1'b1, 4'd2, 4'd1, 4'd2, 16'h5678, "w_r2");
        check("r12_rs1", rs1, 16'h1234);
        check("r12_rs2", rs2, 16'h5678);
        cycle(1'b1, 1'b1, 4'd1, 4'd1, 4'd2, 16'hDEAD, "w_r1b");
        check("r1b_rs1", rs1, 16'hDEAD);
        check("r1b_rs2", rs2, 16'h5678);

        // Write r3 while reading it. The before-edge value is checked inside
        // cycle(); the after-edge value is checked here.
        cycle(1'b1, 1'b1, 4'd3, 4'd3, 4'd0, 16'hAAAA, "w_r3");
        check("r3_post_rs1", rs1, 16'hAAAA);
        check("r3_post_rs2", rs2, 16'h0000);

        // Mid-operation reset with we=1: the write is discarded.
        cycle(1'b0, 1'b1, 4'd1, 4'd1, 4'd2, 16'h7777, "mid_reset");
        check("mid_reset_rs1", rs1, 16'h0000);
        check("mid_reset_rs2", rs2, 16'h0000);
        cycle(1'b1, 1'b0, 4'd0, 4'd3, 4'd1, 16'h0000, "after_reset");
        check("after_reset_r3", rs1, 16'h0000);

        // Write a ladder of values, reading (i, i-1) after each write.
        for (int i = 1; i <= 7; i++) begin
            cycle(1'b1, 1'b1, 4'(i), 4'(i), 4'(i - 1), 16'(i * 16'h1111), "ladder");
            check("ladder_rs1", rs1, 16'(i * 16'h1111));
            check("ladder_rs2", rs2, 16'((i - 1) * 16'h1111));
        end

        // With we=0, nothing changes.
        cycle(1'b1, 1'b0, 4'd9, 4'd9, 4'd9, 16'hBEEF, "we0");
        check("we0_r9", rs1, 16'h0000);

        // Randomized traffic: occasional resets, and read addresses that
        // often hit the write address.
        for (int k = 0; k < 400; k++) begin
            logic         r;
            logic         w;
            logic [N-1:0] rd;
            logic [N-1:0] a1;
            logic [N-1:0] a2;
            r  = ($urandom_range(0, 24) != 0);
            w  = 1'($urandom_range(0, 1));
            rd = 4'($urandom_range(0, DEPTH - 1));
            a1 = ($urandom_range(0, 2) == 0) ? rd : 4'($urandom_range(0, DEPTH - 1));
            a2 = ($urandom_range(0, 2) == 0) ? rd : 4'($urandom_range(0, DEPTH - 1));
            cycle(r, w, rd, a1, a2, 16'($urandom), "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
